pulse_stretch: RTL and testbench

PULSE_STRETCH -- requirements
Module: pulse_stretch

---
 rtl/pulse_stretch.sv | 140 ++++++++++++++
 tb/tb_pulse_stretch.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// Event pulse stretcher: each i_pulse event becomes a HIGH_CYC-wide o_pulse,
// spaced by GAP_CYC low cycles. Define PULSE_STRETCH_OVF_EN for a sticky overflow flag.
module pulse_stretch #(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 4,
    parameter int PEND_W   = 4
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              i_pulse,
    output logic              o_pulse,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_ovf
);

    localparam int MAXC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HIGH_LD = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              pulse_q, pulse_d;

    logic boundary;
    logic pend_nz;
    logic pend_full;
    logic take_pend;
    logic take_pulse;
    logic start;
    logic inc;
    logic dec;

    // A start may happen from IDLE or on the final GAP cycle; clr suppresses it.
    always_comb begin
        boundary   = (state_q == IDLE) ||
                     ((state_q == GAP) && (cnt_q == '0));
        pend_nz    = (pend_q != '0);
        pend_full  = (pend_q == '1);
        take_pend  = boundary && !clr && pend_nz;
        take_pulse = boundary && !clr && !pend_nz && i_pulse;
        start      = take_pend || take_pulse;
        inc        = i_pulse && !clr && !take_pulse;
        dec        = take_pend;
    end

    // Pending queue: +1 per unconsumed event, -1 per queued start, saturating.
    always_comb begin
        pend_d = pend_q;
        if (clr) begin
            pend_d = '0;
        end else if (inc && !dec && !pend_full) begin
            pend_d = pend_q + 1'b1;
        end else if (dec && !inc) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // State, shared duration counter, pending count and output register.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state and counter reload on entry to HIGH or GAP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = HIGH;
            end
            HIGH: begin
                if (cnt_q == '0) state_d = GAP;
            end
            GAP: begin
                if (cnt_q == '0) state_d = start ? HIGH : IDLE;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if ((state_d == HIGH) && (state_q != HIGH)) begin
            cnt_d = HIGH_LD;
        end else if ((state_d == GAP) && (state_q != GAP)) begin
            cnt_d = GAP_LD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Outputs: o_pulse is a flop that mirrors the HIGH state.
    always_comb begin
        pulse_d   = (state_d == HIGH);
        o_pulse   = pulse_q;
        o_busy    = (state_q != IDLE) || pend_nz;
        o_pending = pend_q;
    end

`ifdef PULSE_STRETCH_OVF_EN
    logic ovf_q;
    logic drop;

    assign drop = inc && !dec && pend_full;

    // Sticky record of any event lost to saturation.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch (HIGH_CYC=4, GAP_CYC=2, PEND_W=2).
// Cycle n is the period after the n-th edge following reset release.
module tb_pulse_stretch;

    logic       i_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       i_pulse = 1'b0;
    logic       o_pulse;
    logic       o_busy;
    logic [1:0] o_pending;
    logic       o_ovf;

    int checks = 0;
    int failures = 0;

    pulse_stretch #(
        .HIGH_CYC(4),
        .GAP_CYC (2),
        .PEND_W  (2)
    ) dut (
        .i_clk    (i_clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .i_pulse  (i_pulse),
        .o_pulse  (o_pulse),
        .o_busy   (o_busy),
        .o_pending(o_pending),
        .o_ovf    (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] r;
        r = '0;
        for (int i = a; i <= b; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                   tag, c, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reset, then run ncyc cycles of directed stimulus against
    // hand-computed per-cycle masks of expected outputs.
    task automatic run(input string name, input int ncyc,
                       input logic [63:0] pin, input logic [63:0] cm,
                       input logic [63:0] ep, input logic [63:0] eb,
                       input logic [63:0] el, input logic [63:0] eh,
                       input logic [63:0] eo);
        rst_n = 1'b0;
        i_pulse = 1'b0;
        clr = 1'b0;
        tick();
        chk({name, ":rst_pulse"}, -1, 32'(o_pulse), 0);
        chk({name, ":rst_busy"}, -1, 32'(o_busy), 0);
        chk({name, ":rst_pend"}, -1, 32'(o_pending), 0);
        chk({name, ":rst_ovf"}, -1, 32'(o_ovf), 0);
        rst_n = 1'b1;
        tick();
        for (int c = 0; c < ncyc; c++) begin
            i_pulse = pin[c];
            clr = cm[c];
            chk({name, ":pulse"}, c, 32'(o_pulse), 32'(ep[c]));
            chk({name, ":busy"}, c, 32'(o_busy), 32'(eb[c]));
            chk({name, ":pend"}, c, 32'(o_pending), 32'({eh[c], el[c]}));
            chk({name, ":ovf"}, c, 32'(o_ovf), 32'(eo[c]));
            tick();
        end
        i_pulse = 1'b0;
        clr = 1'b0;
    endtask

    logic [63:0] ovf3;

    initial begin
`ifdef PULSE_STRETCH_OVF_EN
        ovf3 = rng(15, 40);
`else
        ovf3 = '0;
`endif

        // Single event
        run("single", 24, rng(10, 10), '0,
            rng(11, 14), rng(11, 16), '0, '0, '0);

        // Back-to-back events queue up
        run("b2b", 34, rng(10, 12), '0,
            rng(11, 14) | rng(17, 20) | rng(23, 26),
            rng(11, 28),
            rng(12, 12) | rng(17, 22),
            rng(13, 16), '0);

        // Saturation at 3, one event dropped, then clr
        run("ovf", 45, rng(10, 14), rng(40, 40),
            rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32),
            rng(11, 34),
            rng(12, 12) | rng(14, 16) | rng(23, 28),
            rng(13, 22), ovf3);

        // New event on the last GAP cycle restarts without idling
        run("bound", 28, rng(10, 10) | rng(16, 16), '0,
            rng(11, 14) | rng(17, 20), rng(11, 22), '0, '0, '0);

        // clr with two events pending: current pulse finishes only
        run("clr", 24, rng(10, 12), rng(13, 13),
            rng(11, 14), rng(11, 16),
            rng(12, 12), rng(13, 13), '0);

        // Asynchronous reset in HIGH with two events pending
        run("arst", 13, rng(10, 12), '0,
            rng(11, 12), rng(11, 12),
            rng(12, 12), '0, '0);
        chk("arst:pre_pulse", 13, 32'(o_pulse), 1);
        chk("arst:pre_pend", 13, 32'(o_pending), 2);
        #2;
        rst_n = 1'b0;
        i_pulse = 1'b1;
        #1;
        chk("arst:pulse", 13, 32'(o_pulse), 0);
        chk("arst:pend", 13, 32'(o_pending), 0);
        chk("arst:busy", 13, 32'(o_busy), 0);
        chk("arst:ovf", 13, 32'(o_ovf), 0);
        tick();
        tick();
        i_pulse = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("post:pulse", c, 32'(o_pulse), 0);
            chk("post:busy", c, 32'(o_busy), 0);
            chk("post:pend", c, 32'(o_pending), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
